// File: rtl/regfile_dp_if.sv
// Register-file access bundle: write-op bus in, two
// tri-stated read buses and INC/DEC flags out.
interface regfile_dp_if #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 5
);
  logic [2:0]        op;
  logic [ADDR_W-1:0] wid;
  logic [WIDTH-1:0]  din;
  logic              ra_en;
  logic [ADDR_W-1:0] ra_id;
  logic              rb_en;
  logic [ADDR_W-1:0] rb_id;
  logic [WIDTH-1:0]  douta;
  logic [WIDTH-1:0]  doutb;
  logic              zero;
  logic              carry;

  modport master (
    output op, wid, din,
    output ra_en, ra_id, rb_en, rb_id,
    input  douta, doutb, zero, carry
  );

  modport slave (
    input  op, wid, din,
    input  ra_en, ra_id, rb_en, rb_id,
    output douta, doutb, zero, carry
  );
endinterface

// File: rtl/regfile_dp.sv
// SRP16 dual-read register file with one op-driven
// write port and INC/DEC zero/carry flags.
module regfile_dp #(
  parameter int               WIDTH     = 16,
  parameter int               ADDR_W    = 5,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic       clk,
  input  logic       rst,
  regfile_dp_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int H     = WIDTH / 2;

  typedef enum logic [2:0] {
    OP_NOP    = 3'b000,
    OP_WRITE  = 3'b001,
    OP_WRITEU = 3'b010,
    OP_WRITEL = 3'b011,
    OP_INC    = 3'b100,
    OP_DEC    = 3'b101,
    OP_CLR    = 3'b110,
    OP_MOVE   = 3'b111
  } op_e;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] cur;
  logic [WIDTH-1:0] src;
  logic [WIDTH-1:0] wdata_d;
  logic             we_d;
  logic             zero_q, zero_d;
  logic             carry_q, carry_d;

  assign cur = mem_q[bus.wid];
  assign src = mem_q[bus.ra_id];

  // Flags derive from the pre-edge operand, not the sum.
  always_comb begin
    we_d    = 1'b1;
    wdata_d = cur;
    zero_d  = zero_q;
    carry_d = carry_q;
    unique case (op_e'(bus.op))
      OP_NOP:    we_d = 1'b0;
      OP_WRITE:  wdata_d = bus.din;
      OP_WRITEU: wdata_d = {bus.din[H-1:0], cur[H-1:0]};
      OP_WRITEL: wdata_d = {cur[WIDTH-1:H], bus.din[H-1:0]};
      OP_INC: begin
        wdata_d = cur + WIDTH'(1);
        zero_d  = &cur;
        carry_d = &cur;
      end
      OP_DEC: begin
        wdata_d = cur - WIDTH'(1);
        zero_d  = (cur == WIDTH'(1));
        carry_d = ~|cur;
      end
      OP_CLR:    wdata_d = '0;
      OP_MOVE:   wdata_d = src;
      default:   we_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= RESET_VAL;
      end
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      if (we_d) begin
        mem_q[bus.wid] <= wdata_d;
      end
      zero_q  <= zero_d;
      carry_q <= carry_d;
    end
  end

  assign bus.douta = bus.ra_en ? mem_q[bus.ra_id] : 'z;
  assign bus.doutb = bus.rb_en ? mem_q[bus.rb_id] : 'z;
  assign bus.zero  = zero_q;
  assign bus.carry = carry_q;
endmodule

// File: tb/tb_regfile_dp.sv
// Bench for regfile_dp: array/flag model checked every
// cycle plus directed vectors with literal expectations.
module tb_regfile_dp;
  localparam int W = 16;
  localparam int A = 5;
  localparam int D = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_dp_if #(.WIDTH(W), .ADDR_W(A)) bus ();

  regfile_dp #(
    .WIDTH(W), .ADDR_W(A), .RESET_VAL('0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [W-1:0] m [D];
  logic         mz, mc;
  bit           armed = 1'b0;
  int           tests = 0;
  int           fails = 0;

  task automatic chk(input string nm,
                     input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // A released bus may resolve to Z or to an undriven 0.
  task automatic chk_rd(input string nm,
                        input logic [W-1:0] act,
                        input logic en,
                        input logic [W-1:0] exp);
    if (en) begin
      chk(nm, act, exp);
    end else begin
      tests++;
      if (!(act === 'z || act === '0)) begin
        fails++;
        $display("FAIL %s: got %h expected zzzz", nm, act);
      end
    end
  endtask

  // Model: registers as plain values, flags from wide arithmetic.
  always @(posedge clk) begin
    logic [W:0]   t;
    logic [W-1:0] s;
    if (rst) begin
      for (int i = 0; i < D; i++) m[i] = '0;
      mz = 1'b0;
      mc = 1'b0;
      armed = 1'b1;
    end else if (armed) begin
      s = m[bus.ra_id];
      case (bus.op)
        3'd1: m[bus.wid] = bus.din;
        3'd2: m[bus.wid] = {bus.din[7:0], m[bus.wid][7:0]};
        3'd3: m[bus.wid] = {m[bus.wid][15:8], bus.din[7:0]};
        3'd4: begin
          t = {1'b0, m[bus.wid]} + 17'd1;
          m[bus.wid] = t[W-1:0];
          mc = t[W];
          mz = (t[W-1:0] == 0);
        end
        3'd5: begin
          t = {1'b0, m[bus.wid]} - 17'd1;
          m[bus.wid] = t[W-1:0];
          mc = t[W];
          mz = (t[W-1:0] == 0);
        end
        3'd6: m[bus.wid] = '0;
        3'd7: m[bus.wid] = s;
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk_rd("cmp_a", bus.douta, bus.ra_en, m[bus.ra_id]);
      chk_rd("cmp_b", bus.doutb, bus.rb_en, m[bus.rb_id]);
      chk("cmp_zero", W'(bus.zero), W'(mz));
      chk("cmp_carry", W'(bus.carry), W'(mc));
    end
  end

  task automatic drive(input logic [2:0] o,
                       input logic [A-1:0] w,
                       input logic [W-1:0] d,
                       input logic r = 1'b0);
    bus.op  = o;
    bus.wid = w;
    bus.din = d;
    rst     = r;
    @(posedge clk);
    #1;
    bus.op = 3'd0;
    rst    = 1'b0;
  endtask

  task automatic rd(input logic ea, input logic [A-1:0] a,
                    input logic eb, input logic [A-1:0] b);
    bus.ra_en = ea;
    bus.ra_id = a;
    bus.rb_en = eb;
    bus.rb_id = b;
    #1;
  endtask

  task automatic flags(input string nm, input logic z,
                       input logic c);
    chk({nm, "_zero"}, W'(bus.zero), W'(z));
    chk({nm, "_carry"}, W'(bus.carry), W'(c));
  endtask

  initial begin
    rst = 1'b0;
    bus.op = 3'd0;
    bus.wid = '0;
    bus.din = '0;
    bus.ra_en = 1'b0;
    bus.ra_id = '0;
    bus.rb_en = 1'b0;
    bus.rb_id = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    // Reset with a pending WRITE that must be dropped
    drive(3'd1, 5'd4, 16'hDEAD, 1'b1);
    for (int i = 0; i < D; i++) begin
      rd(1'b1, A'(i), 1'b1, A'(i));
      chk("rst_a", bus.douta, 16'h0000);
      chk("rst_b", bus.doutb, 16'h0000);
    end
    flags("rst", 1'b0, 1'b0);

    // Half writes
    rd(1'b1, 5'd3, 1'b0, 5'd0);
    drive(3'd1, 5'd3, 16'h1234);
    chk("wr", bus.douta, 16'h1234);
    drive(3'd2, 5'd3, 16'h00AB);
    chk("writeu", bus.douta, 16'hAB34);
    drive(3'd3, 5'd3, 16'h00CD);
    chk("writel", bus.douta, 16'hABCD);
    flags("half", 1'b0, 1'b0);

    // Counter wrap
    rd(1'b1, 5'd7, 1'b0, 5'd0);
    drive(3'd1, 5'd7, 16'hFFFE);
    drive(3'd4, 5'd7, 16'h0);
    chk("inc1", bus.douta, 16'hFFFF);
    flags("inc1", 1'b0, 1'b0);
    drive(3'd4, 5'd7, 16'h0);
    chk("inc2", bus.douta, 16'h0000);
    flags("inc2", 1'b1, 1'b1);
    drive(3'd5, 5'd7, 16'h0);
    chk("dec", bus.douta, 16'hFFFF);
    flags("dec", 1'b0, 1'b1);
    drive(3'd1, 5'd3, 16'h5555);
    flags("hold", 1'b0, 1'b1);

    // DEC to zero then wrap
    rd(1'b1, 5'd10, 1'b0, 5'd0);
    drive(3'd6, 5'd10, 16'h0);
    drive(3'd4, 5'd10, 16'h0);
    flags("inc01", 1'b0, 1'b0);
    drive(3'd5, 5'd10, 16'h0);
    chk("dec0", bus.douta, 16'h0000);
    flags("dec0", 1'b1, 1'b0);
    drive(3'd5, 5'd10, 16'h0);
    chk("decwrap", bus.douta, 16'hFFFF);
    flags("decwrap", 1'b0, 1'b1);

    // Dual read and tri-state
    drive(3'd1, 5'd1, 16'h1111);
    drive(3'd1, 5'd2, 16'h2222);
    rd(1'b1, 5'd1, 1'b1, 5'd2);
    chk("dual_a", bus.douta, 16'h1111);
    chk("dual_b", bus.doutb, 16'h2222);
    rd(1'b1, 5'd1, 1'b0, 5'd2);
    chk_rd("tri_b", bus.doutb, 1'b0, 16'h0);
    rd(1'b0, 5'd2, 1'b1, 5'd2);
    chk_rd("tri_a", bus.douta, 1'b0, 16'h0);
    chk("tri_b_on", bus.doutb, 16'h2222);
    rd(1'b1, 5'd1, 1'b1, 5'd1);
    chk("same_a", bus.douta, 16'h1111);
    chk("same_b", bus.doutb, 16'h1111);

    // Collision: old value before the edge, new after
    rd(1'b1, 5'd5, 1'b0, 5'd0);
    bus.op  = 3'd1;
    bus.wid = 5'd5;
    bus.din = 16'hBEEF;
    #1;
    chk("coll_old", bus.douta, 16'h0000);
    @(posedge clk);
    #1;
    bus.op = 3'd0;
    chk("coll_new", bus.douta, 16'hBEEF);

    // MOVE and CLR
    rd(1'b1, 5'd5, 1'b1, 5'd9);
    drive(3'd7, 5'd9, 16'h0);
    chk("move", bus.doutb, 16'hBEEF);
    drive(3'd6, 5'd5, 16'h0);
    chk("clr", bus.douta, 16'h0000);
    chk("clr_keep", bus.doutb, 16'hBEEF);
    rd(1'b1, 5'd9, 1'b1, 5'd9);
    drive(3'd7, 5'd9, 16'h0);
    chk("move_self", bus.douta, 16'hBEEF);

    // Reset in the middle of a count
    rd(1'b1, 5'd0, 1'b1, 5'd9);
    drive(3'd4, 5'd0, 16'h0);
    drive(3'd4, 5'd0, 16'h0);
    chk("cnt2", bus.douta, 16'h0002);
    drive(3'd4, 5'd0, 16'h0, 1'b1);
    chk("midrst", bus.douta, 16'h0000);
    chk("midrst_r9", bus.doutb, 16'h0000);
    flags("midrst", 1'b0, 1'b0);
    drive(3'd4, 5'd0, 16'h0);
    chk("postrst", bus.douta, 16'h0001);
    flags("postrst", 1'b0, 1'b0);

    @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
